// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM encoding and the word geometry.
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: load request, byte stream, memory write port, status.
// master = host/stream source side, slave = loader side.
interface imem_loader_if #(
   parameter int ADDR_WIDTH  = 12,
   parameter int INSTR_WIDTH = 32
);
   logic                     start;
   logic [ADDR_WIDTH-1:0]    base_addr;
   logic [ADDR_WIDTH:0]      byte_count;
   logic                     s_valid;
   logic [7:0]               s_data;
   logic                     s_ready;
   logic                     mem_we;
   logic [ADDR_WIDTH-1:0]    mem_addr;
   logic [INSTR_WIDTH-1:0]   mem_wdata;
   logic [INSTR_WIDTH/8-1:0] mem_be;
   logic                     busy;
   logic                     done;
   logic [7:0]               checksum;

   modport master (
      output start, base_addr, byte_count, s_valid, s_data,
      input  s_ready, mem_we, mem_addr, mem_wdata, mem_be,
      input  busy, done, checksum
   );

   modport slave (
      input  start, base_addr, byte_count, s_valid, s_data,
      output s_ready, mem_we, mem_addr, mem_wdata, mem_be,
      output busy, done, checksum
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into a word with lane enables.
// Ports: clear, byte_en/byte_data in; lane_cnt, word, be out.
module imem_byte_packer
   import imem_pkg::*;
#(
   parameter int W = 8 * BYTES_PER_WORD
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 byte_en,
   input  logic [7:0]           byte_data,
   output logic [$clog2(W/8)-1:0] lane_cnt,
   output logic [W-1:0]         word,
   output logic [W/8-1:0]       be
);
   localparam int NB = W / 8;
   localparam int LW = $clog2(NB);

   logic [LW-1:0] lane_q, lane_d;
   logic [W-1:0]  word_q, word_d;
   logic [NB-1:0] be_q, be_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q <= '0;
         word_q <= '0;
         be_q   <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
         be_q   <= be_d;
      end
   end

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      be_d   = be_q;
      if (clear) begin
         lane_d = '0;
         word_d = '0;
         be_d   = '0;
      end else if (byte_en) begin
         word_d[8*lane_q +: 8] = byte_data;
         be_d[lane_q]          = 1'b1;
         lane_d                = lane_q + LW'(1);
      end
   end

   assign lane_cnt = lane_q;
   assign word     = word_q;
   assign be       = be_q;
endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a byte stream, one word write per word.
// Ports: clk, rst, bus (slave): request, stream, mem write, status.
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int INSTR_WIDTH = 8 * BYTES_PER_WORD
) (
   input  logic          clk,
   input  logic          rst,
   imem_loader_if.slave  bus
);
   localparam int LW = $clog2(BYTES_PER_WORD);

   loader_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic [7:0]            csum_q, csum_d;

   logic                  clear;
   logic                  accept;
   logic [LW-1:0]         lane_cnt;

   imem_byte_packer #(.W(INSTR_WIDTH)) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .byte_en   (accept),
      .byte_data (bus.s_data),
      .lane_cnt  (lane_cnt),
      .word      (bus.mem_wdata),
      .be        (bus.mem_be)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         csum_q  <= csum_d;
      end
   end

   assign accept = (state_q == RECV) && bus.s_valid;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      csum_d  = csum_q;
      clear   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               addr_d  = {bus.base_addr[ADDR_WIDTH-1:2], 2'b00};
               rem_d   = bus.byte_count;
               csum_d  = '0;
               clear   = 1'b1;
               state_d = (bus.byte_count != '0) ? RECV : DONE;
            end
         end
         RECV: begin
            if (accept) begin
               csum_d = csum_q + bus.s_data;
               rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
               // word full, or this was the final byte of the load
               if (lane_cnt == LW'(BYTES_PER_WORD - 1) ||
                   rem_q == (ADDR_WIDTH+1)'(1))
                  state_d = WRITE;
            end
         end
         WRITE: begin
            clear   = 1'b1;
            addr_d  = addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
            state_d = (rem_q == '0) ? DONE : RECV;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.s_ready  = (state_q == RECV);
   assign bus.mem_we   = (state_q == WRITE);
   assign bus.mem_addr = addr_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.checksum = csum_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed table, random loads
// against a word-list reference model, reset and zero-length cases.
module tb_imem_loader;
   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   typedef struct {
      logic [11:0] base;
      int          count;
      logic [63:0] bytes;
      int          nwr;
      wr_t         w0;
      wr_t         w1;
      logic [7:0]  csum;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if bus ();

   imem_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   wr_t  got [$];
   wr_t  exp_q [$];
   logic [7:0] stim [4096];
   vec_t tbl [4];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      if (bus.mem_we) begin
         got.push_back({bus.mem_addr, bus.mem_wdata, bus.mem_be});
         chk("ready_in_write", 64'(bus.s_ready), 64'd0);
      end
      if (bus.done) done_cnt++;
   end

   // Reference: the list of word writes a load must produce.
   task automatic model(input logic [11:0] base, input int count,
                        output logic [7:0] csum);
      int a;
      wr_t w;
      exp_q.delete();
      csum = 8'd0;
      for (int i = 0; i < count; i++) csum = csum + stim[i];
      for (int wi = 0; wi * 4 < count; wi++) begin
         w = '0;
         a = ((int'(base) / 4) * 4 + 4 * wi) % 4096;
         w.addr = a[11:0];
         for (int k = 0; k < 4; k++) begin
            if (wi * 4 + k < count) begin
               w.data = w.data | (32'(stim[wi*4+k]) << (8 * k));
               w.be[k] = 1'b1;
            end
         end
         exp_q.push_back(w);
      end
   endtask

   task automatic run_load(input logic [11:0] base, input int count,
                           input int gap, input bit mid_start,
                           input logic [7:0] exp_csum);
      int idx = 0;
      int cyc = 0;
      int d0;
      got.delete();
      d0 = done_cnt;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.byte_count = 13'(count);
      @(negedge clk);
      bus.start = 1'b0;
      while (done_cnt == d0 && cyc < count * 12 + 50) begin
         if (idx < count && $urandom_range(99) >= gap) begin
            bus.s_valid = 1'b1;
            bus.s_data  = stim[idx];
         end else begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
         end
         if (mid_start && cyc == 5) begin
            bus.start      = 1'b1;
            bus.base_addr  = 12'h800;
            bus.byte_count = 13'd2;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.s_valid && bus.s_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      bus.s_valid = 1'b0;
      bus.start   = 1'b0;
      chk("done_seen", 64'(done_cnt != d0), 64'd1);
      repeat (3) @(negedge clk);
      chk("done_pulses", 64'(done_cnt - d0), 64'd1);
      chk("checksum", 64'(bus.checksum), 64'(exp_csum));
      chk("busy_idle", 64'(bus.busy), 64'd0);
   endtask

   task automatic cmp_model;
      wr_t g;
      chk("write_count", 64'(got.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
         g = (i < got.size()) ? got[i] : '0;
         chk($sformatf("write%0d", i), 64'(g), 64'(exp_q[i]));
      end
   endtask

   initial begin
      logic [7:0] cs;
      logic [11:0] rb;
      int rc;
      wr_t g;

      tbl[0] = '{12'h000, 8, 64'h0010_0093_0000_0013, 2,
                 {12'h000, 32'h0000_0013, 4'hF},
                 {12'h004, 32'h0010_0093, 4'hF}, 8'hB6};
      tbl[1] = '{12'h100, 6, 64'h0000_0605_0403_0201, 2,
                 {12'h100, 32'h0403_0201, 4'hF},
                 {12'h104, 32'h0000_0605, 4'h3}, 8'h15};
      tbl[2] = '{12'hFFC, 8, 64'h1817_1615_1413_1211, 2,
                 {12'hFFC, 32'h1413_1211, 4'hF},
                 {12'h000, 32'h1817_1615, 4'hF}, 8'hA4};
      tbl[3] = '{12'h0FE, 4, 64'h0000_0000_DDCC_BBAA, 1,
                 {12'h0FC, 32'hDDCC_BBAA, 4'hF},
                 48'h0, 8'h0E};

      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.byte_count = '0;
      bus.s_valid    = 1'b0;
      bus.s_data     = '0;
      #2;
      chk("rst_ready", 64'(bus.s_ready), 64'd0);
      chk("rst_we", 64'(bus.mem_we), 64'd0);
      chk("rst_mem", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_be}), 64'd0);
      chk("rst_status", 64'({bus.busy, bus.done, bus.checksum}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // directed table, gapless and then with gaps + ignored start
      for (int pass = 0; pass < 2; pass++) begin
         foreach (tbl[t]) begin
            for (int k = 0; k < 8; k++) stim[k] = tbl[t].bytes[8*k +: 8];
            run_load(tbl[t].base, tbl[t].count, pass * 40, pass == 1,
                     tbl[t].csum);
            chk($sformatf("tbl%0d_nwr", t), 64'(got.size()),
                64'(tbl[t].nwr));
            g = (got.size() > 0) ? got[0] : '0;
            chk($sformatf("tbl%0d_w0", t), 64'(g), 64'(tbl[t].w0));
            if (tbl[t].nwr > 1) begin
               g = (got.size() > 1) ? got[1] : '0;
               chk($sformatf("tbl%0d_w1", t), 64'(g), 64'(tbl[t].w1));
            end
         end
      end

      // zero length: done in the cycle after start, no write
      got.delete();
      stim[0] = 8'h55;
      run_load(12'h040, 0, 0, 1'b0, 8'h00);
      chk("zero_writes", 64'(got.size()), 64'd0);
      @(negedge clk);
      bus.start      = 1'b1;
      bus.byte_count = '0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("zero_done", 64'({bus.done, bus.busy}), 64'b11);
      @(posedge clk);
      #1;
      chk("zero_after", 64'({bus.done, bus.busy, bus.mem_we}), 64'd0);

      // reset after 2 of 8 bytes
      got.delete();
      for (int k = 0; k < 8; k++) stim[k] = 8'(8'hA0 + k);
      @(negedge clk);
      bus.start      = 1'b1;
      bus.base_addr  = 12'h200;
      bus.byte_count = 13'd8;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = stim[0];
      @(negedge clk);
      bus.s_data = stim[1];
      @(negedge clk);
      bus.s_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_ready_we", 64'({bus.s_ready, bus.mem_we}), 64'd0);
      chk("mrst_mem", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_be}), 64'd0);
      chk("mrst_status", 64'({bus.busy, bus.done, bus.checksum}), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("mrst_no_write", 64'(got.size()), 64'd0);
      model(12'h300, 4, cs);
      run_load(12'h300, 4, 0, 1'b0, cs);
      cmp_model();

      // random loads against the reference model
      for (int r = 0; r < 8; r++) begin
         rb = 12'($urandom);
         rc = (r == 7) ? 4096 : int'($urandom_range(0, 40));
         for (int i = 0; i < rc; i++) stim[i] = 8'($urandom);
         model(rb, rc, cs);
         run_load(rb, rc, (r == 7) ? 0 : int'($urandom_range(0, 60)),
                  r[0], cs);
         cmp_model();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
